// File: rtl/spi_upcounter_pkg.sv
// Shared types and frame layout for the up-counter SPI link.
//   seq_state_t : frame sequencer states
//   HDR_*       : bit positions/width of the header byte (byte0)
//   make_hdr    : assembles byte0 from status bits and counter high bits
package spi_upcounter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START_HI,
    WAIT_HI,
    START_LO,
    WAIT_LO,
    HOLD,
    GAP
  } seq_state_t;

  localparam int HDR_RUN_BIT = 7;
  localparam int HDR_CLR_BIT = 6;
  localparam int HDR_VAL_W   = 6;

  function automatic logic [7:0] make_hdr(input logic                 run,
                                          input logic                 clr,
                                          input logic [HDR_VAL_W-1:0] val);
    logic [7:0] h;
    h                  = '0;
    h[HDR_VAL_W-1:0]   = val;
    h[HDR_CLR_BIT]     = clr;
    h[HDR_RUN_BIT]     = run;
    return h;
  endfunction

endpackage

// File: rtl/spi_counter_tx_sequencer.sv
// Frame sequencer between the counter control unit and a byte-level SPI
// master. Each frame is two bytes under a frame-level chip select:
//   byte0 = {runstop, clear, counter[DATA_W-1:8] zero-extended to 6 bits}
//   byte1 = counter[7:0]
// followed by GAP_CYCLES cycles of chip select high. Requests arriving while
// a frame is in flight collapse into one follow-up frame.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   i_counter    counter value (DATA_W bits)
//   i_runstop    run status
//   i_clear      clear status
//   i_update     one-cycle frame request
//   i_ready      SPI master can accept a byte
//   i_done       SPI master byte-complete pulse
//   o_start      one-cycle byte start (gated by i_ready)
//   o_tx_data    byte being sent, held from o_start until i_done
//   o_ss_n       frame chip select, active low (registered)
//   o_busy       sequencer not idle (registered)
module spi_counter_tx_sequencer
  import spi_upcounter_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_counter,
  input  logic              i_runstop,
  input  logic              i_clear,
  input  logic              i_update,
  input  logic              i_ready,
  input  logic              i_done,
  output logic              o_start,
  output logic [7:0]        o_tx_data,
  output logic              o_ss_n,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  seq_state_t           state, state_nx;
  logic                 pending;
  logic [7:0]           hdr_q, lo_q;
  logic [CNT_W-1:0]     gap_cnt;
  logic                 ss_n_q, busy_q;
  logic [HDR_VAL_W-1:0] hi_val;
  logic                 enter_setup, enter_gap, gap_last;

  // Upper counter bits, zero-extended into the 6-bit header field.
  always_comb begin
    hi_val                = '0;
    hi_val[DATA_W-9:0]    = i_counter[DATA_W-1:8];
  end

  // Last GAP cycle; the ==0 term only guards against an out-of-sequence value.
  assign gap_last = (gap_cnt == CNT_W'(1)) || (gap_cnt == '0);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (i_update || pending) state_nx = SETUP;
      SETUP:    state_nx = START_HI;
      START_HI: if (i_ready) state_nx = WAIT_HI;
      WAIT_HI:  if (i_done)  state_nx = START_LO;
      START_LO: if (i_ready) state_nx = WAIT_LO;
      WAIT_LO:  if (i_done)  state_nx = HOLD;
      HOLD:     state_nx = GAP;
      // Only the already-latched pending flag is looked at here; a request on
      // the exit edge itself is latched and picked up from IDLE next cycle.
      GAP:      if (gap_last) state_nx = pending ? SETUP : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign enter_setup = (state_nx == SETUP) && (state != SETUP);
  assign enter_gap   = (state_nx == GAP)   && (state != GAP);

  // Byte handshake decode.
  always_comb begin
    o_start   = 1'b0;
    o_tx_data = '0;
    case (state)
      START_HI: begin o_start = i_ready; o_tx_data = hdr_q; end
      WAIT_HI:  o_tx_data = hdr_q;
      START_LO: begin o_start = i_ready; o_tx_data = lo_q;  end
      WAIT_LO:  o_tx_data = lo_q;
      default:  ;
    endcase
  end

  assign o_ss_n = ss_n_q;
  assign o_busy = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      hdr_q   <= '0;
      lo_q    <= '0;
      gap_cnt <= '0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      ss_n_q <= (state_nx == IDLE) || (state_nx == GAP);
      busy_q <= (state_nx != IDLE);

      // The snapshot on the SETUP edge already reflects a request arriving on
      // that same edge, so clearing takes priority over setting.
      if (enter_setup) begin
        pending <= 1'b0;
        hdr_q   <= make_hdr(i_runstop, i_clear, hi_val);
        lo_q    <= i_counter[7:0];
      end else if (i_update && (state != IDLE)) begin
        pending <= 1'b1;
      end

      if (enter_gap)
        gap_cnt <= CNT_W'(GAP_CYCLES);
      else if ((state == GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_counter_tx_sequencer.sv
module tb_spi_counter_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] counter;
  logic        runstop, clear, update, update2;
  logic        m_ready, m_done, stall, stray;
  logic        i_ready, i_done;
  logic        start1, ss1, busy1, start2, ss2, busy2;
  logic [7:0]  tx1, tx2;

  assign i_ready = m_ready & ~stall;
  assign i_done  = m_done | stray;

  always #5 clk = ~clk;

  spi_counter_tx_sequencer #(.DATA_W(14), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .i_counter(counter), .i_runstop(runstop),
    .i_clear(clear), .i_update(update), .i_ready(i_ready), .i_done(i_done),
    .o_start(start1), .o_tx_data(tx1), .o_ss_n(ss1), .o_busy(busy1));

  spi_counter_tx_sequencer #(.DATA_W(14), .GAP_CYCLES(1)) dut_g1 (
    .clk(clk), .reset(reset), .i_counter(counter), .i_runstop(runstop),
    .i_clear(clear), .i_update(update2), .i_ready(i_ready), .i_done(i_done),
    .o_start(start2), .o_tx_data(tx2), .o_ss_n(ss2), .o_busy(busy2));

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI master model: byte accepted on an o_start cycle, i_done 16 cycles later.
  int   spi_cnt = 0;
  logic start_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (reset) begin
      spi_cnt    = 0;
      start_seen = 1'b0;
    end else if (start_seen) begin
      spi_cnt    = 16;
      start_seen = 1'b0;
    end else if (spi_cnt > 0) begin
      spi_cnt--;
      if (spi_cnt == 0) m_done = 1'b1;
    end
    m_ready = (spi_cnt == 0);
  end

  // Monitor: byte log, frame counts, gap length, start-pulse rules.
  logic [7:0] bytes_q[$];
  logic [7:0] bytes2_q[$];
  int   start_q[$];
  int   frames1 = 0, frames2 = 0, last_fall = 0, gap_run = 0, last_gap = 0, viol = 0;
  logic prev_ss1 = 1'b1, prev_ss2 = 1'b1, prev_st1 = 1'b0, prev_st2 = 1'b0;
  always @(negedge clk) begin
    if (start1) begin bytes_q.push_back(tx1); start_q.push_back(cyc); start_seen = 1'b1; end
    if (start2) begin bytes2_q.push_back(tx2); start_seen = 1'b1; end
    if ((start1 && (ss1 || prev_st1)) || (start2 && (ss2 || prev_st2))) viol++;
    prev_st1 = start1;
    prev_st2 = start2;
    if (prev_ss1 && !ss1) begin frames1++; last_fall = cyc; end
    if (prev_ss2 && !ss2) frames2++;
    prev_ss1 = ss1;
    prev_ss2 = ss2;
    if (busy1 && ss1) gap_run++;
    else begin
      if (gap_run != 0) last_gap = gap_run;
      gap_run = 0;
    end
  end

  int upd_cyc;
  task automatic pulse_upd();
    @(posedge clk); #1;
    update  = 1'b1;
    upd_cyc = cyc;
    @(posedge clk); #1;
    update  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (bytes_q.size() < n && k < 300) begin @(negedge clk); #1; k++; end
    chk(tag, bytes_q.size(), n);
  endtask

  task automatic wait_idle(input logic second, input string tag);
    int k = 0;
    while ((second ? busy2 : busy1) && k < 300) begin @(negedge clk); #1; k++; end
    chk(tag, second ? busy2 : busy1, 1'b0);
  endtask

  initial begin
    int b, f, n_hi, n_st, rel_cyc, k;
    logic found;
    reset = 1'b1; counter = '0; runstop = 0; clear = 0;
    update = 0; update2 = 0; stall = 0; stray = 0; m_done = 0; m_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ss_n", ss1, 1'b1);
    chk("rst_start", start1, 1'b0);
    chk("rst_tx", tx1, 8'h00);
    chk("rst_busy", busy1, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame
    counter = 14'h2A5B; runstop = 1; clear = 0;
    b = bytes_q.size(); f = frames1;
    pulse_upd();
    wait_bytes(b + 2, "t1_bytes");
    wait_idle(1'b0, "t1_idle");
    @(negedge clk); #1;
    chk("t1_ss_fall", last_fall, upd_cyc + 1);
    chk("t1_start", start_q[b], upd_cyc + 2);
    chk("t1_b0", bytes_q[b], 8'hAA);
    chk("t1_b1", bytes_q[b+1], 8'h5B);
    chk("t1_frames", frames1, f + 1);
    chk("t1_gap", last_gap, 4);

    // Snapshot hold
    counter = 14'd100; runstop = 0; clear = 0;
    b = bytes_q.size();
    pulse_upd();
    wait_bytes(b + 1, "t2_first");
    @(posedge clk); #1;
    counter = 14'd200;
    wait_idle(1'b0, "t2_idle");
    chk("t2_b0", bytes_q[b], 8'h00);
    chk("t2_b1", bytes_q[b+1], 8'h64);

    // Coalescing: three requests in frame 1, follow-up carries the last value
    counter = 14'd1234; runstop = 1; clear = 1;
    b = bytes_q.size(); f = frames1;
    pulse_upd();
    repeat (3) @(posedge clk);
    counter = 14'd5000; pulse_upd();
    repeat (3) @(posedge clk);
    counter = 14'd7000; pulse_upd();
    repeat (3) @(posedge clk);
    counter = 14'd9999; runstop = 0; clear = 0; pulse_upd();
    wait_idle(1'b0, "t3_idle");
    repeat (20) @(negedge clk);
    #1;
    chk("t3_frames", frames1, f + 2);
    chk("t3_nbytes", bytes_q.size(), b + 4);
    chk("t3_f1b0", bytes_q[b], 8'hC4);
    chk("t3_f1b1", bytes_q[b+1], 8'hD2);
    chk("t3_f2b0", bytes_q[b+2], 8'h27);
    chk("t3_f2b1", bytes_q[b+3], 8'h0F);

    // Back-pressure in START_HI
    @(posedge clk); #1;
    stall = 1;
    b = bytes_q.size(); f = frames1;
    pulse_upd();
    n_hi = 0;
    repeat (6) begin @(negedge clk); #1; n_hi += ss1; end
    chk("t4_no_start", bytes_q.size(), b);
    chk("t4_ss_low", n_hi, 0);
    @(posedge clk); #1;
    stall = 0;
    rel_cyc = cyc;
    wait_bytes(b + 2, "t4_bytes");
    wait_idle(1'b0, "t4_idle");
    chk("t4_start_cyc", start_q[b], rel_cyc);
    chk("t4_frames", frames1, f + 1);

    // Stray i_done in IDLE
    f = frames1;
    @(posedge clk); #1;
    stray = 1;
    @(posedge clk); #1;
    stray = 0;
    @(negedge clk); #1;
    chk("t5_stray_busy", busy1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_stray_frames", frames1, f);

    // Reset while in WAIT_LO
    b = bytes_q.size();
    pulse_upd();
    wait_bytes(b + 2, "t5_bytes");
    f = frames1;
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("t5_rst_ss_n", ss1, 1'b1);
    chk("t5_rst_start", start1, 1'b0);
    chk("t5_rst_busy", busy1, 1'b0);
    chk("t5_rst_tx", tx1, 8'h00);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    #1;
    chk("t5_no_retry", frames1, f);
    chk("t5_idle", busy1, 1'b0);

    // GAP_CYCLES=1, request on the GAP exit edge
    counter = 14'd9999; runstop = 0; clear = 0;
    f = frames2;
    @(posedge clk); #1; update2 = 1;
    @(posedge clk); #1; update2 = 0;
    found = 1'b0; k = 0;
    while (!found && k < 200) begin
      @(negedge clk); #1; k++;
      if (busy2 && ss2) found = 1'b1;
    end
    chk("t6_gap_seen", found, 1'b1);
    update2 = 1;
    @(posedge clk); #1;
    update2 = 0;
    @(negedge clk); #1;
    chk("t6_idle_busy", busy2, 1'b0);
    chk("t6_idle_ss", ss2, 1'b1);
    @(negedge clk); #1;
    chk("t6_setup_busy", busy2, 1'b1);
    chk("t6_setup_ss", ss2, 1'b0);
    wait_idle(1'b1, "t6_done");
    repeat (10) @(negedge clk);
    #1;
    chk("t6_frames", frames2, f + 2);
    chk("t6_b0", bytes2_q[2], 8'h27);
    chk("t6_b1", bytes2_q[3], 8'h0F);

    n_st = viol;
    chk("start_rules", n_st, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
